// File: rtl/pipe_stage_skid_if.sv
// Valid/ready handshake bundle for the skid pipeline stage.
// master = upstream/downstream driver, slave = the stage itself.
interface pipe_stage_skid_if #(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 8
) ();
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;

    modport master (
        output in_valid, in_data, in_ctrl, out_ready,
        input  in_ready, out_valid, out_data, out_ctrl
    );

    modport slave (
        input  in_valid, in_data, in_ctrl, out_ready,
        output in_ready, out_valid, out_data, out_ctrl
    );
endinterface

// File: rtl/pipe_stage_skid.sv
// Two-entry skid pipeline stage with registered in_ready,
// flush with saturating kill counter.
module pipe_stage_skid #(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    pipe_stage_skid_if.slave bus,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] kill_cnt
);
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_e;

    state_e            state_q;
    logic [DATA_W-1:0] main_data_q;
    logic [DATA_W-1:0] skid_data_q;
    logic [CTRL_W-1:0] main_ctrl_q;
    logic [CTRL_W-1:0] skid_ctrl_q;
    logic              rdy_q;
    logic [CNT_W-1:0]  kill_q;

    logic              vld;
    logic              accept;
    logic              take;
    logic [CNT_W:0]    kill_sum;
    logic [CNT_W-1:0]  kill_d;

    assign vld    = (state_q != S_EMPTY);
    assign accept = bus.in_valid && rdy_q;
    assign take   = vld && bus.out_ready;

    assign kill_sum = {1'b0, kill_q} + {{(CNT_W-1){1'b0}}, occupancy};
    assign kill_d   = kill_sum[CNT_W] ? '1 : kill_sum[CNT_W-1:0];

    assign occupancy     = state_q;
    assign kill_cnt      = kill_q;
    assign bus.in_ready  = rdy_q;
    assign bus.out_valid = vld;
    assign bus.out_data  = main_data_q;
    // A bubble must never carry live control bits downstream
    assign bus.out_ctrl  = vld ? main_ctrl_q : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_EMPTY;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
            rdy_q       <= 1'b1;
            kill_q      <= '0;
        end else if (flush) begin
            state_q     <= S_EMPTY;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
            rdy_q       <= 1'b1;
            kill_q      <= kill_d;
        end else begin
            unique case (state_q)
                S_EMPTY: begin
                    if (accept) begin
                        main_data_q <= bus.in_data;
                        main_ctrl_q <= bus.in_ctrl;
                        state_q     <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (accept && take) begin
                        main_data_q <= bus.in_data;
                        main_ctrl_q <= bus.in_ctrl;
                    end else if (accept) begin
                        skid_data_q <= bus.in_data;
                        skid_ctrl_q <= bus.in_ctrl;
                        state_q     <= S_FULL;
                        rdy_q       <= 1'b0;
                    end else if (take) begin
                        state_q <= S_EMPTY;
                    end
                end
                S_FULL: begin
                    // Input is not sampled here: rdy_q is low
                    if (take) begin
                        main_data_q <= skid_data_q;
                        main_ctrl_q <= skid_ctrl_q;
                        state_q     <= S_ONE;
                        rdy_q       <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_EMPTY;
                    rdy_q   <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: directed scenarios
// plus a random run against a queue scoreboard.
module tb_pipe_stage_skid;
    localparam int DW = 128;
    localparam int CW = 8;
    localparam int KW = 16;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } ent_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          flush = 1'b0;
    logic [1:0]    occ;
    logic [KW-1:0] kill;

    logic          s_flush = 1'b0;
    logic [1:0]    s_occ;
    logic [3:0]    s_kill;

    pipe_stage_skid_if #(.DATA_W(DW), .CTRL_W(CW)) bus ();
    pipe_stage_skid_if #(.DATA_W(8), .CTRL_W(4)) sbus ();

    pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(KW)) dut (
        .clk(clk), .reset(reset), .flush(flush), .bus(bus),
        .occupancy(occ), .kill_cnt(kill)
    );

    // Narrow counter instance so saturation is reachable quickly
    pipe_stage_skid #(.DATA_W(8), .CTRL_W(4), .CNT_W(4)) sdut (
        .clk(clk), .reset(reset), .flush(s_flush), .bus(sbus),
        .occupancy(s_occ), .kill_cnt(s_kill)
    );

    always #5 clk = ~clk;

    int   vec = 0;
    int   err = 0;
    ent_t mq[$];
    int   mkill = 0;

    task automatic drive(input logic v, input logic [DW-1:0] d,
                         input logic [CW-1:0] c, input logic r,
                         input logic f, output logic took,
                         output ent_t obs, output ent_t exp);
        ent_t e;
        int   n;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_ctrl   = c;
        bus.out_ready = r;
        flush         = f;
        obs.d = bus.out_data;
        obs.c = bus.out_ctrl;
        took  = 1'b0;
        exp   = '0;
        e.d   = d;
        e.c   = c;
        @(posedge clk);
        n = mq.size();
        if (f) begin
            mkill = (mkill + n > 65535) ? 65535 : mkill + n;
            mq.delete();
        end else begin
            if (n > 0 && r) begin
                took = 1'b1;
                exp  = mq.pop_front();
            end
            if (v && n < 2) mq.push_back(e);
        end
        #1;
    endtask

    task automatic test_reset();
        #23;
        vec++; if (bus.out_valid !== 1'b0) begin err++;
            $display("FAIL rst_valid: got %0b want 0", bus.out_valid); end
        vec++; if (bus.in_ready !== 1'b1) begin err++;
            $display("FAIL rst_ready: got %0b want 1", bus.in_ready); end
        vec++; if (occ !== 2'd0) begin err++;
            $display("FAIL rst_occ: got %0d want 0", occ); end
        vec++; if (kill !== 16'd0) begin err++;
            $display("FAIL rst_kill: got %0h want 0", kill); end
        vec++; if (bus.out_data !== '0) begin err++;
            $display("FAIL rst_data: got %0h want 0", bus.out_data); end
        vec++; if (bus.out_ctrl !== '0) begin err++;
            $display("FAIL rst_ctrl: got %0h want 0", bus.out_ctrl); end
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_first();
        logic t;
        ent_t o, x;
        logic [DW-1:0] pat;
        pat = 128'h0123_4567_89AB_CDEF_0011_2233_4455_66A5;
        drive(1'b1, pat, 8'h1F, 1'b1, 1'b0, t, o, x);
        vec++; if (bus.out_valid !== 1'b1) begin err++;
            $display("FAIL first_valid: got %0b want 1", bus.out_valid); end
        vec++; if (bus.out_data !== pat) begin err++;
            $display("FAIL first_data: got %0h want %0h", bus.out_data, pat); end
        vec++; if (bus.out_ctrl !== 8'h1F) begin err++;
            $display("FAIL first_ctrl: got %0h want 1f", bus.out_ctrl); end
        vec++; if (occ !== 2'd1) begin err++;
            $display("FAIL first_occ: got %0d want 1", occ); end
        drive(1'b0, '0, '0, 1'b1, 1'b0, t, o, x);
        vec++; if (t !== 1'b1 || o !== x) begin err++;
            $display("FAIL first_take: got %0h want %0h", o, x); end
        vec++; if (bus.out_valid !== 1'b0 || bus.out_ctrl !== '0) begin err++;
            $display("FAIL first_drain: got v=%0b c=%0h want v=0 c=0",
                     bus.out_valid, bus.out_ctrl); end
    endtask

    task automatic test_backpressure();
        logic t;
        ent_t o, x;
        int   nxt = 1;
        int   got = 0;
        int   pre;
        for (int i = 0; i < 4; i++) begin
            pre = mq.size();
            drive(1'b1, DW'(nxt), CW'(nxt), 1'b0, 1'b0, t, o, x);
            if (pre < 2) nxt++;
            if (i == 1) begin
                vec++; if (bus.in_ready !== 1'b0) begin err++;
                    $display("FAIL bp_ready: got %0b want 0", bus.in_ready); end
                vec++; if (occ !== 2'd2) begin err++;
                    $display("FAIL bp_occ: got %0d want 2", occ); end
            end
            vec++; if (bus.out_data !== DW'(1) || bus.out_ctrl !== CW'(1)) begin
                err++;
                $display("FAIL bp_hold: got %0h/%0h want 1/1",
                         bus.out_data, bus.out_ctrl); end
        end
        for (int i = 0; i < 20 && got < 4; i++) begin
            pre = mq.size();
            drive(nxt <= 4, DW'(nxt), CW'(nxt), 1'b1, 1'b0, t, o, x);
            if (nxt <= 4 && pre < 2) nxt++;
            if (t) begin
                got++;
                vec++; if (o !== x || o.d !== DW'(got)) begin err++;
                    $display("FAIL bp_order: got %0h want %0h", o.d, got); end
            end
        end
        vec++; if (got !== 4) begin err++;
            $display("FAIL bp_count: got %0d want 4", got); end
    endtask

    task automatic test_back_to_back();
        logic t;
        ent_t o, x;
        for (int i = 0; i < 7; i++) begin
            drive(i < 6, DW'(10 + i), CW'(i + 1), 1'b1, 1'b0, t, o, x);
            if (i > 0) begin
                vec++; if (t !== 1'b1 || o !== x) begin err++;
                    $display("FAIL b2b_take%0d: got %0h want %0h", i, o, x); end
            end
            vec++; if (bus.in_ready !== 1'b1) begin err++;
                $display("FAIL b2b_ready%0d: got %0b want 1", i, bus.in_ready); end
        end
    endtask

    task automatic test_flush();
        logic t;
        ent_t o, x;
        drive(1'b1, DW'(5), CW'(5), 1'b0, 1'b0, t, o, x);
        drive(1'b1, DW'(6), CW'(6), 1'b0, 1'b0, t, o, x);
        vec++; if (occ !== 2'd2) begin err++;
            $display("FAIL fl_fill: got %0d want 2", occ); end
        drive(1'b1, DW'(7), CW'(7), 1'b1, 1'b1, t, o, x);
        vec++; if (occ !== 2'd0 || bus.out_valid !== 1'b0) begin err++;
            $display("FAIL fl_empty: got occ=%0d v=%0b want 0/0",
                     occ, bus.out_valid); end
        vec++; if (bus.out_ctrl !== '0) begin err++;
            $display("FAIL fl_ctrl: got %0h want 0", bus.out_ctrl); end
        vec++; if (kill !== 16'd2) begin err++;
            $display("FAIL fl_kill: got %0d want 2", kill); end
        vec++; if (bus.in_ready !== 1'b1) begin err++;
            $display("FAIL fl_ready: got %0b want 1", bus.in_ready); end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, '0, '0, 1'b1, 1'b0, t, o, x);
            vec++; if (bus.out_valid !== 1'b0) begin err++;
                $display("FAIL fl_ghost%0d: got %0h want none", i, bus.out_data); end
        end
    endtask

    task automatic test_saturate();
        bus.in_valid = 1'b0;
        flush        = 1'b0;
        sbus.in_data = 8'h3C;
        sbus.in_ctrl = 4'h5;
        sbus.out_ready = 1'b0;
        for (int k = 0; k < 9; k++) begin
            sbus.in_valid = 1'b1;
            repeat (2) begin @(posedge clk); #1; end
            sbus.in_valid = 1'b0;
            s_flush = 1'b1;
            @(posedge clk); #1;
            s_flush = 1'b0;
            if (k == 6) begin
                vec++; if (s_kill !== 4'hE) begin err++;
                    $display("FAIL sat_preset: got %0h want e", s_kill); end
            end
            if (k >= 7) begin
                vec++; if (s_kill !== 4'hF) begin err++;
                    $display("FAIL sat_full%0d: got %0h want f", k, s_kill); end
            end
        end
        s_flush = 1'b1;
        @(posedge clk); #1;
        s_flush = 1'b0;
        vec++; if (s_kill !== 4'hF || s_occ !== 2'd0) begin err++;
            $display("FAIL sat_idle: got %0h/%0d want f/0", s_kill, s_occ); end
    endtask

    task automatic test_async_reset();
        logic t;
        ent_t o, x;
        drive(1'b1, DW'(8), CW'(8), 1'b0, 1'b0, t, o, x);
        drive(1'b1, DW'(9), CW'(9), 1'b0, 1'b0, t, o, x);
        #3;
        bus.in_valid = 1'b0;
        reset = 1'b0;
        #1;
        vec++; if (bus.out_valid !== 1'b0 || occ !== 2'd0) begin err++;
            $display("FAIL ar_state: got v=%0b occ=%0d want 0/0",
                     bus.out_valid, occ); end
        vec++; if (bus.out_data !== '0 || bus.out_ctrl !== '0) begin err++;
            $display("FAIL ar_out: got %0h/%0h want 0/0",
                     bus.out_data, bus.out_ctrl); end
        vec++; if (kill !== 16'd0 || bus.in_ready !== 1'b1) begin err++;
            $display("FAIL ar_kill: got k=%0d r=%0b want 0/1",
                     kill, bus.in_ready); end
        mq.delete();
        mkill = 0;
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        drive(1'b1, DW'(51), CW'(3), 1'b1, 1'b0, t, o, x);
        vec++; if (bus.out_valid !== 1'b1 || bus.out_data !== DW'(51) ||
                   occ !== 2'd1 || kill !== 16'd0) begin err++;
            $display("FAIL ar_first: got v=%0b d=%0h occ=%0d k=%0d want 1/33/1/0",
                     bus.out_valid, bus.out_data, occ, kill); end
    endtask

    task automatic test_random();
        logic t;
        ent_t o, x;
        logic [DW-1:0] d;
        for (int i = 0; i < 10000; i++) begin
            vec++; if (bus.out_valid !== (mq.size() != 0) ||
                       occ !== 2'(mq.size()) ||
                       bus.in_ready !== (mq.size() < 2)) begin err++;
                $display("FAIL rnd_state%0d: got v=%0b occ=%0d r=%0b want occ=%0d",
                         i, bus.out_valid, occ, bus.in_ready, mq.size()); end
            vec++; if (kill !== KW'(mkill)) begin err++;
                $display("FAIL rnd_kill%0d: got %0d want %0d", i, kill, mkill); end
            if (mq.size() != 0) begin
                vec++; if (bus.out_data !== mq[0].d || bus.out_ctrl !== mq[0].c) begin
                    err++;
                    $display("FAIL rnd_head%0d: got %0h/%0h want %0h/%0h", i,
                             bus.out_data, bus.out_ctrl, mq[0].d, mq[0].c); end
            end else begin
                vec++; if (bus.out_ctrl !== '0) begin err++;
                    $display("FAIL rnd_bubble%0d: got %0h want 0", i, bus.out_ctrl); end
            end
            d = {$urandom(), $urandom(), $urandom(), $urandom()};
            drive($urandom_range(0, 3) != 0, d, CW'($urandom()),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0,
                  t, o, x);
            if (t) begin
                vec++; if (o !== x) begin err++;
                    $display("FAIL rnd_take%0d: got %0h want %0h", i, o, x); end
            end
        end
    endtask

    initial begin
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.in_ctrl    = '0;
        bus.out_ready  = 1'b0;
        sbus.in_valid  = 1'b0;
        sbus.in_data   = '0;
        sbus.in_ctrl   = '0;
        sbus.out_ready = 1'b0;
        test_reset();
        test_first();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_saturate();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 Parameter DATA_W, default 128, SHALL set the datapath payload width (alu/pc/rs2/inst packed).
REQ-002 Parameter CTRL_W, default 8, SHALL set the control-bit width (MemRW, regWEn, WBSel, datain, dataOutAddj packed).
REQ-003 Parameter CNT_W, default 16, SHALL set the kill-counter width.
REQ-004 clk  input  1  SHALL be the single clock; all state SHALL update on posedge clk.
REQ-005 reset  input  1  SHALL be an asynchronous, active-low reset.
REQ-006 flush  input  1  SHALL be a synchronous kill of all held entries.
REQ-007 in_valid  input  1  SHALL mark the upstream payload as valid.
REQ-008 in_ready  output  1  SHALL indicate the stage accepts input this cycle.
REQ-009 in_data  input  DATA_W  SHALL be the upstream datapath payload.
REQ-010 in_ctrl  input  CTRL_W  SHALL be the upstream control bits.
REQ-011 out_valid  output  1  SHALL mark out_data/out_ctrl as valid.
REQ-012 out_ready  input  1  SHALL indicate downstream accepts output this cycle.
REQ-013 out_data  output  DATA_W  SHALL be the head-entry datapath payload.
REQ-014 out_ctrl  output  CTRL_W  SHALL be the head-entry control bits.
REQ-015 occupancy  output  2  SHALL report held entries (0, 1 or 2).
REQ-016 kill_cnt  output  CNT_W  SHALL count valid entries discarded by flush.

Function
REQ-017 Storage SHALL be two entries: main (drives outputs) and skid; state SHALL be EMPTY (0), ONE (main valid), or FULL (main and skid valid).
REQ-018 in_ready SHALL be a registered signal equal to 1 in EMPTY and ONE, 0 in FULL; it SHALL NOT depend combinationally on out_ready.
REQ-019 Accept SHALL be in_valid && in_ready; take SHALL be out_valid && out_ready.
REQ-020 EMPTY: accept -> ONE, main <= input; else hold.
REQ-021 ONE: accept && take -> ONE, main <= input; accept && !take -> FULL, skid <= input; !accept && take -> EMPTY; else hold.
REQ-022 FULL: take -> ONE, main <= skid; else hold; input SHALL NOT be sampled.
REQ-023 Latency SHALL be one cycle from accept in EMPTY to out_valid=1; sustained throughput SHALL be one entry per cycle with out_ready held high.
REQ-024 Entry order SHALL be preserved; no entry SHALL be duplicated or lost except by flush.
REQ-025 out_valid SHALL equal (occupancy != 0); occupancy SHALL equal the state encoding.
REQ-026 out_ctrl SHALL be forced to all-zeros whenever out_valid=0, so a bubble never writes registers or memory.
REQ-027 flush SHALL have priority over accept and take: next state EMPTY, both entries' data and ctrl zeroed, any input presented that cycle dropped, in_ready=1 next cycle.
REQ-028 On flush, kill_cnt SHALL increase by the pre-flush occupancy (0, 1 or 2), saturating at all-ones.
REQ-029 out_data and out_ctrl SHALL remain stable while out_valid=1 and out_ready=0.

Reset
REQ-030 reset=0 SHALL immediately, independent of clk, force state EMPTY, occupancy=0, out_valid=0, out_data=0, out_ctrl=0, in_ready=1, kill_cnt=0.
REQ-031 Reset asserted mid-transfer SHALL discard all entries without incrementing kill_cnt; first accept after release SHALL behave as from EMPTY.

Verification
REQ-032 Reset release, in_valid=1, in_data=0x...A5, in_ctrl=0x1F, out_ready=1 -> next cycle out_valid=1, out_data=0x...A5, out_ctrl=0x1F, occupancy=1.
REQ-033 Stream 4 entries 1,2,3,4 with out_ready=0 -> after 2 accepts in_ready=0, occupancy=2, out_data=1 held; raise out_ready -> outputs 1,2,3,4 in order, no loss.
REQ-034 FULL with flush=1 and in_valid=1 (data 7) -> next cycle occupancy=0, out_valid=0, out_ctrl=0, kill_cnt=2, entry 7 never appears.
REQ-035 kill_cnt preset to 0xFFFE via repeated flushes, flush with occupancy=2 -> kill_cnt=0xFFFF, and stays 0xFFFF on further flushes.
REQ-036 reset=0 asserted between clock edges while occupancy=2 -> outputs zero before next posedge, kill_cnt=0, in_ready=1.
REQ-037 Random valid/ready/flush for 10k cycles against a queue scoreboard -> no ordering, duplication or stability violation.
